// File: rtl/mux2to1_packet_arbiter_if.sv
// -----------------------------------------------------------------------------
// mux2to1_packet_arbiter_if
//   Bundle of the three valid/ready packet streams around the 2:1 packet
//   arbiter: two source streams (a, b) and one sink stream (y).
//
//   Signals (per stream): <x>_valid, <x>_data[WIDTH-1:0], <x>_last, <x>_ready
//
//   Modports:
//     master - the environment side: drives a/b beats and y_ready,
//              observes a_ready/b_ready and the y beat.
//     slave  - the arbiter side: consumes a/b beats, drives the readies and
//              the registered y beat, observes y_ready.
// -----------------------------------------------------------------------------
interface mux2to1_packet_arbiter_if #(
  parameter int WIDTH = 8
);
  logic             a_valid;
  logic [WIDTH-1:0] a_data;
  logic             a_last;
  logic             a_ready;

  logic             b_valid;
  logic [WIDTH-1:0] b_data;
  logic             b_last;
  logic             b_ready;

  logic             y_valid;
  logic [WIDTH-1:0] y_data;
  logic             y_last;
  logic             y_ready;

  modport master (
    output a_valid, a_data, a_last,
    input  a_ready,
    output b_valid, b_data, b_last,
    input  b_ready,
    input  y_valid, y_data, y_last,
    output y_ready
  );

  modport slave (
    input  a_valid, a_data, a_last,
    output a_ready,
    input  b_valid, b_data, b_last,
    output b_ready,
    output y_valid, y_data, y_last,
    input  y_ready
  );
endinterface

// File: rtl/mux2to1_packet_arbiter.sv
// -----------------------------------------------------------------------------
// mux2to1_packet_arbiter
//   Packet-level round-robin arbiter sharing one 2:1 datapath mux between two
//   valid/ready packet sources and driving a single registered output stage.
//   A grant is held from the first beat of a packet until its last beat has
//   been accepted, so packets never interleave on the output.
//
//   Ports:
//     clk        system clock, rising edge
//     rst        asynchronous active-high reset
//     bus        stream bundle (slave modport): a_*, b_* sources, y_* sink
//     sel        registered mux select, 0 = a, 1 = b
//     busy       a packet grant is currently held
// -----------------------------------------------------------------------------
module mux2to1_packet_arbiter #(
  parameter int WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  mux2to1_packet_arbiter_if.slave bus,
  output logic                    sel,
  output logic                    busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_A = 2'd1,
    GNT_B = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic             sel_q, sel_d;
  logic             last_served_q, last_served_d;  // 0 = a, 1 = b
  logic             y_valid_q, y_valid_d;
  logic             y_last_q, y_last_d;
  logic [WIDTH-1:0] y_data_q, y_data_d;

  logic             out_free;
  logic             a_ready;
  logic             b_ready;
  logic             a_fire;
  logic             b_fire;
  logic             load;
  logic [WIDTH-1:0] mux_data;
  logic             mux_last;

  // The output register can take a new beat when it is empty or is being
  // drained this same cycle; this keeps the block at one beat per cycle.
  assign out_free = ~y_valid_q | bus.y_ready;

  assign a_ready  = (state_q == GNT_A) & out_free;
  assign b_ready  = (state_q == GNT_B) & out_free;
  assign a_fire   = bus.a_valid & a_ready;
  assign b_fire   = bus.b_valid & b_ready;
  assign load     = a_fire | b_fire;

  // The shared datapath mux, steered by the registered select.
  assign mux_data = sel_q ? bus.b_data : bus.a_data;
  assign mux_last = sel_q ? bus.b_last : bus.a_last;

  always_comb begin
    state_d       = state_q;
    sel_d         = sel_q;
    last_served_d = last_served_q;
    y_valid_d     = y_valid_q;
    y_data_d      = y_data_q;
    y_last_d      = y_last_q;

    unique case (state_q)
      IDLE: begin
        // Round-robin tie break: a wins unless a was the last one served.
        if (bus.a_valid && (!bus.b_valid || last_served_q)) begin
          state_d = GNT_A;
          sel_d   = 1'b0;
        end else if (bus.b_valid) begin
          state_d = GNT_B;
          sel_d   = 1'b1;
        end
      end
      GNT_A: begin
        if (a_fire && bus.a_last) begin
          state_d       = IDLE;
          last_served_d = 1'b0;
        end
      end
      GNT_B: begin
        if (b_fire && bus.b_last) begin
          state_d       = IDLE;
          last_served_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // A load takes priority over a drain: the new beat simply replaces the
    // one leaving, so y_valid stays high across back-to-back beats.
    if (load) begin
      y_valid_d = 1'b1;
      y_data_d  = mux_data;
      y_last_d  = mux_last;
    end else if (y_valid_q && bus.y_ready) begin
      y_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      sel_q         <= 1'b0;
      last_served_q <= 1'b1;
      y_valid_q     <= 1'b0;
      y_data_q      <= '0;
      y_last_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      sel_q         <= sel_d;
      last_served_q <= last_served_d;
      y_valid_q     <= y_valid_d;
      y_data_q      <= y_data_d;
      y_last_q      <= y_last_d;
    end
  end

  assign bus.a_ready = a_ready;
  assign bus.b_ready = b_ready;
  assign bus.y_valid = y_valid_q;
  assign bus.y_data  = y_data_q;
  assign bus.y_last  = y_last_q;
  assign sel         = sel_q;
  assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_mux2to1_packet_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mux2to1_packet_arbiter
//   Self-checking bench for mux2to1_packet_arbiter. Directed scenario tasks
//   plus a stream engine that feeds packet queues into both sources with
//   random mid-packet valid gaps and random output back-pressure, and checks
//   the output against a packet-level round-robin ordering of those queues.
// -----------------------------------------------------------------------------
module tb_mux2to1_packet_arbiter;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst;
  logic sel;
  logic busy;

  int vectors     = 0;
  int miscompares = 0;

  // Beats are stored as {last, data}.
  logic [8:0] a_pk[$];
  logic [8:0] b_pk[$];
  logic [8:0] exp_q[$];

  mux2to1_packet_arbiter_if #(.WIDTH(W)) bus ();

  mux2to1_packet_arbiter #(.WIDTH(W)) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus),
    .sel  (sel),
    .busy (busy)
  );

  always #5 clk = ~clk;

  task automatic idle_inputs();
    bus.a_valid = 1'b0; bus.a_data = '0; bus.a_last = 1'b0;
    bus.b_valid = 1'b0; bus.b_data = '0; bus.b_last = 1'b0;
    bus.y_ready = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Packet-level round robin: whichever requester still has packets and was
  // not served last goes next; a goes first after reset.
  task automatic build_expected();
    int   ai = 0;
    int   bi = 0;
    logic ls = 1'b1;
    logic pick;
    exp_q.delete();
    while (ai < a_pk.size() || bi < b_pk.size()) begin
      if (ai < a_pk.size() && (ls == 1'b1 || bi >= b_pk.size())) pick = 1'b0;
      else pick = 1'b1;
      if (!pick) begin
        do begin exp_q.push_back(a_pk[ai]); ai++; end while (!a_pk[ai-1][8]);
      end else begin
        do begin exp_q.push_back(b_pk[bi]); bi++; end while (!b_pk[bi-1][8]);
      end
      ls = pick;
    end
  endtask

  task automatic gen_packets(input int na, input int nb, input int max_len);
    logic [8:0] beat;
    int len;
    a_pk.delete();
    b_pk.delete();
    for (int p = 0; p < na; p++) begin
      len = $urandom_range(max_len, 1);
      for (int k = 0; k < len; k++) begin
        beat[8]   = (k == len - 1);
        beat[7:0] = 8'($urandom_range(255, 0));
        a_pk.push_back(beat);
      end
    end
    for (int p = 0; p < nb; p++) begin
      len = $urandom_range(max_len, 1);
      for (int k = 0; k < len; k++) begin
        beat[8]   = (k == len - 1);
        beat[7:0] = 8'($urandom_range(255, 0));
        b_pk.push_back(beat);
      end
    end
  endtask

  // Streams a_pk / b_pk through the DUT from reset and checks the y stream,
  // handshake rules, select, stall stability and the inter-packet gap.
  task automatic run_stream(input string name, input int gap_pct, input int stall_pct,
                            input int b_start, input int budget);
    int         ai = 0, bi = 0, oi = 0, cyc = 0, last_end = 0;
    logic       a_first = 1'b1, b_first = 1'b1;
    logic       a_f = 1'b0, b_f = 1'b0, prev_stall = 1'b0;
    logic [8:0] prev_y = '0;
    int         fails_before = miscompares;

    build_expected();
    do_reset();
    while (oi < exp_q.size() && cyc < budget) begin
      if (a_f) begin
        a_first = a_pk[ai][8];
        if (a_pk[ai][8]) last_end = cyc;
        ai++;
      end
      if (b_f) begin
        b_first = b_pk[bi][8];
        if (b_pk[bi][8]) last_end = cyc;
        bi++;
      end
      if (ai < a_pk.size()) begin
        if (a_first) bus.a_valid = 1'b1;
        else if (bus.a_valid && !a_f) bus.a_valid = 1'b1;
        else bus.a_valid = ($urandom_range(99, 0) >= gap_pct);
        bus.a_data = a_pk[ai][7:0];
        bus.a_last = a_pk[ai][8];
      end else begin
        bus.a_valid = 1'b0;
      end
      if (bi < b_pk.size() && cyc >= b_start) begin
        if (b_first) bus.b_valid = 1'b1;
        else if (bus.b_valid && !b_f) bus.b_valid = 1'b1;
        else bus.b_valid = ($urandom_range(99, 0) >= gap_pct);
        bus.b_data = b_pk[bi][7:0];
        bus.b_last = b_pk[bi][8];
      end else begin
        bus.b_valid = 1'b0;
      end
      bus.y_ready = ($urandom_range(99, 0) >= stall_pct);

      @(negedge clk);
      vectors++;
      if ((bus.a_ready & bus.b_ready) !== 1'b0) begin
        miscompares++;
        $display("FAIL %s both_ready cyc %0d: a_ready=%b b_ready=%b required not both 1", name, cyc, bus.a_ready, bus.b_ready);
      end
      if (bus.y_valid && !bus.y_ready) begin
        vectors++;
        if ((bus.a_ready | bus.b_ready) !== 1'b0) begin
          miscompares++;
          $display("FAIL %s ready_in_stall cyc %0d: a_ready=%b b_ready=%b required 0", name, cyc, bus.a_ready, bus.b_ready);
        end
      end
      if (prev_stall) begin
        vectors++;
        if ({bus.y_valid, bus.y_last, bus.y_data} !== {1'b1, prev_y}) begin
          miscompares++;
          $display("FAIL %s stall_hold cyc %0d: got v=%b %h required v=1 %h", name, cyc, bus.y_valid, {bus.y_last, bus.y_data}, prev_y);
        end
      end
      if (bus.y_valid && bus.y_ready) begin
        vectors++;
        if ({bus.y_last, bus.y_data} !== exp_q[oi]) begin
          miscompares++;
          $display("FAIL %s y_beat %0d: got %h required %h", name, oi, {bus.y_last, bus.y_data}, exp_q[oi]);
        end
        oi++;
      end
      a_f = bus.a_valid & bus.a_ready;
      b_f = bus.b_valid & bus.b_ready;
      if (a_f || b_f) begin
        vectors++;
        if ({sel, busy} !== {b_f, 1'b1}) begin
          miscompares++;
          $display("FAIL %s sel_busy cyc %0d: got sel=%b busy=%b required sel=%b busy=1", name, cyc, sel, busy, b_f);
        end
        if ((a_f && a_first) || (b_f && b_first)) begin
          vectors++;
          if (cyc + 1 < last_end + 2) begin
            miscompares++;
            $display("FAIL %s pkt_gap: first beat at edge %0d required >= %0d", name, cyc + 1, last_end + 2);
          end
        end
      end
      prev_stall = bus.y_valid & ~bus.y_ready;
      prev_y     = {bus.y_last, bus.y_data};
      @(posedge clk);
      #1;
      cyc++;
    end
    vectors++;
    if (oi != exp_q.size()) begin
      miscompares++;
      $display("FAIL %s timeout: got %0d beats required %0d", name, oi, exp_q.size());
    end
    bus.a_valid = 1'b0;
    bus.b_valid = 1'b0;
    bus.y_ready = 1'b1;
    @(negedge clk);
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL %s busy_after: got %b required 0", name, busy);
    end
    $display("run %s: %0d beats in %0d cycles, %0d new errors", name, exp_q.size(), cyc, miscompares - fails_before);
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    vectors++;
    if ({bus.y_valid, bus.y_last, bus.y_data} !== 10'h000) begin
      miscompares++;
      $display("FAIL reset_y: got v=%b l=%b d=%h required all 0", bus.y_valid, bus.y_last, bus.y_data);
    end
    vectors++;
    if ({sel, busy, bus.a_ready, bus.b_ready} !== 4'b0000) begin
      miscompares++;
      $display("FAIL reset_ctl: got sel/busy/ar/br=%b required 0000", {sel, busy, bus.a_ready, bus.b_ready});
    end
    #2 rst = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    vectors++;
    if ({busy, bus.y_valid} !== 2'b00) begin
      miscompares++;
      $display("FAIL reset_idle: got busy=%b y_valid=%b required 0 0", busy, bus.y_valid);
    end
    $display("test_reset done");
  endtask

  task automatic test_tie_single_beat();
    a_pk = '{9'h111};
    b_pk = '{9'h122};
    run_stream("tie_single_beat", 0, 0, 0, 50);
  endtask

  task automatic test_no_interleave();
    a_pk = '{9'h0A0, 9'h0A1, 9'h1A2};
    b_pk = '{9'h1B0};
    run_stream("no_interleave", 0, 0, 2, 50);
  endtask

  task automatic test_alternate();
    a_pk = '{9'h101, 9'h103, 9'h105};
    b_pk = '{9'h102, 9'h104, 9'h106};
    run_stream("alternate", 0, 0, 0, 60);
  endtask

  task automatic test_backpressure();
    do_reset();
    bus.a_valid = 1'b1; bus.a_data = 8'h55; bus.a_last = 1'b0; bus.y_ready = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    vectors++;
    if (bus.a_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL bp_first_ready: got %b required 1", bus.a_ready);
    end
    @(posedge clk); #1;
    bus.a_data = 8'h56; bus.a_last = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      vectors++;
      if ({bus.y_valid, bus.y_data, bus.a_ready} !== {1'b1, 8'h55, 1'b0}) begin
        miscompares++;
        $display("FAIL bp_hold %0d: got v=%b d=%h ar=%b required v=1 d=55 ar=0", i, bus.y_valid, bus.y_data, bus.a_ready);
      end
      @(posedge clk); #1;
    end
    bus.y_ready = 1'b1;
    @(negedge clk);
    vectors++;
    if (bus.a_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL bp_release_ready: got %b required 1", bus.a_ready);
    end
    @(posedge clk); #1;
    bus.a_valid = 1'b0;
    @(negedge clk);
    vectors++;
    if ({bus.y_valid, bus.y_last, bus.y_data, busy} !== {1'b1, 1'b1, 8'h56, 1'b0}) begin
      miscompares++;
      $display("FAIL bp_replace: got v=%b l=%b d=%h busy=%b required v=1 l=1 d=56 busy=0", bus.y_valid, bus.y_last, bus.y_data, busy);
    end
    @(posedge clk); #1;
    @(negedge clk);
    vectors++;
    if (bus.y_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL bp_drain: got y_valid=%b required 0", bus.y_valid);
    end
    $display("test_backpressure done");
  endtask

  task automatic test_valid_gap();
    do_reset();
    bus.a_valid = 1'b1; bus.a_data = 8'hC0; bus.a_last = 1'b0;
    bus.b_valid = 1'b1; bus.b_data = 8'hD0; bus.b_last = 1'b1;
    bus.y_ready = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    bus.a_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      vectors++;
      if ({busy, sel, bus.b_ready} !== 3'b100) begin
        miscompares++;
        $display("FAIL gap_hold %0d: got busy/sel/br=%b required 100", i, {busy, sel, bus.b_ready});
      end
      @(posedge clk); #1;
    end
    bus.a_valid = 1'b1; bus.a_data = 8'hC1; bus.a_last = 1'b1;
    @(negedge clk);
    vectors++;
    if (bus.a_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL gap_resume: got a_ready=%b required 1", bus.a_ready);
    end
    @(posedge clk); #1;
    bus.a_valid = 1'b0;
    @(negedge clk);
    vectors++;
    if ({busy, bus.b_ready, bus.y_last, bus.y_data} !== {1'b0, 1'b0, 1'b1, 8'hC1}) begin
      miscompares++;
      $display("FAIL gap_idle: got busy=%b br=%b l=%b d=%h required 0 0 1 c1", busy, bus.b_ready, bus.y_last, bus.y_data);
    end
    @(posedge clk); #1;
    @(negedge clk);
    vectors++;
    if ({sel, busy, bus.b_ready} !== 3'b111) begin
      miscompares++;
      $display("FAIL gap_b_grant: got sel/busy/br=%b required 111", {sel, busy, bus.b_ready});
    end
    @(posedge clk); #1;
    bus.b_valid = 1'b0;
    @(negedge clk);
    vectors++;
    if ({bus.y_valid, bus.y_data} !== {1'b1, 8'hD0}) begin
      miscompares++;
      $display("FAIL gap_b_data: got v=%b d=%h required v=1 d=d0", bus.y_valid, bus.y_data);
    end
    $display("test_valid_gap done");
  endtask

  task automatic test_async_reset();
    do_reset();
    bus.b_valid = 1'b1; bus.b_data = 8'hE0; bus.b_last = 1'b0; bus.y_ready = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    vectors++;
    if ({bus.y_valid, busy, sel} !== 3'b111) begin
      miscompares++;
      $display("FAIL arst_pre: got y_valid/busy/sel=%b required 111", {bus.y_valid, busy, sel});
    end
    #2 rst = 1'b1;
    #1;
    vectors++;
    if ({bus.y_valid, busy, sel, bus.a_ready, bus.b_ready} !== 5'b00000) begin
      miscompares++;
      $display("FAIL arst_clear: got yv/busy/sel/ar/br=%b required 00000", {bus.y_valid, busy, sel, bus.a_ready, bus.b_ready});
    end
    bus.a_valid = 1'b1; bus.a_data = 8'hF0; bus.a_last = 1'b1;
    bus.b_valid = 1'b1; bus.b_data = 8'hF1; bus.b_last = 1'b1;
    bus.y_ready = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    vectors++;
    if ({sel, bus.a_ready, bus.b_ready} !== 3'b010) begin
      miscompares++;
      $display("FAIL arst_a_first: got sel/ar/br=%b required 010", {sel, bus.a_ready, bus.b_ready});
    end
    @(posedge clk); #1;
    bus.a_valid = 1'b0;
    bus.b_valid = 1'b0;
    @(negedge clk);
    vectors++;
    if ({bus.y_valid, bus.y_data} !== {1'b1, 8'hF0}) begin
      miscompares++;
      $display("FAIL arst_a_data: got v=%b d=%h required v=1 d=f0", bus.y_valid, bus.y_data);
    end
    $display("test_async_reset done");
  endtask

  task automatic test_random();
    gen_packets(8, 8, 5);
    run_stream("random_gaps_stalls", 30, 30, 0, 3000);
    gen_packets(10, 10, 4);
    run_stream("random_full_rate", 0, 0, 0, 3000);
    gen_packets(10, 3, 6);
    run_stream("random_unbalanced", 20, 50, 0, 3000);
  endtask

  initial begin
    idle_inputs();
    rst = 1'b1;
    test_reset();
    test_tie_single_beat();
    test_no_interleave();
    test_alternate();
    test_backpressure();
    test_valid_gap();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mux2to1_packet_arbiter.md
Name: mux2to1_packet_arbiter

Overview:
- Shares a single 2:1 datapath mux between two requesters, a and b. Each requester sends packets as valid/ready streams with a last flag.
- Round-robin arbitration per packet. The grant locks to one requester until that packet's last beat is accepted.
- Drives the mux select and a registered output stage feeding one downstream consumer.
- Sits between two packet sources and a single-ported sink.

Parameters:
- WIDTH, 8, data width of a_data, b_data and y_data.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- a_valid  input  1  requester a has a beat.
- a_data  input  WIDTH  requester a data.
- a_last  input  1  a_data is the final beat of a's packet.
- a_ready  output  1  arbiter accepts a's beat this cycle.
- b_valid  input  1  requester b has a beat.
- b_data  input  WIDTH  requester b data.
- b_last  input  1  b_data is the final beat of b's packet.
- b_ready  output  1  arbiter accepts b's beat this cycle.
- y_valid  output  1  output beat present.
- y_data  output  WIDTH  output data, registered.
- y_last  output  1  output last flag, registered.
- y_ready  input  1  downstream accepts y beat.
- sel  output  1  current mux select: 0 = a, 1 = b.
- busy  output  1  a packet grant is held (state not IDLE).

Behaviour:
- Single clock domain: clk. Reset rst is asynchronous, active-high; all flops clear immediately on rst=1.
- Reset values:
  - state = IDLE; y_valid = 0, y_data = 0, y_last = 0; sel = 0; busy = 0; a_ready = b_ready = 0.
  - last_served = 1 (b), so a wins the first tie.
- FSM states: IDLE, GNT_A, GNT_B.
- IDLE:
  - a_ready = b_ready = 0.
  - a_valid only -> GNT_A, sel <= 0.
  - b_valid only -> GNT_B, sel <= 1.
  - Both valid -> grant the requester not equal to last_served.
  - Neither valid -> stay in IDLE; sel holds its value.
- GNT_x:
  - x_ready = ~y_valid | y_ready. This is combinational, so the block sustains 1 beat/cycle.
  - The other requester's ready = 0.
- Transfer: x_valid & x_ready at an edge loads y_data <= x_data, y_last <= x_last, y_valid <= 1.
  - If x_last = 1 on that beat: next state IDLE, last_served <= x.
  - Otherwise stay in GNT_x.
- Output register:
  - On y_valid & y_ready with no new load: y_valid <= 0.
  - Simultaneous drain and load: new beat replaces old, y_valid stays 1.
  - With y_ready=0 and y_valid=1: y_data and y_last hold stable, and x_ready = 0.
- Latency:
  - A beat accepted at edge N is visible on y from after edge N (1 cycle).
  - Grant: valid seen in IDLE at edge N -> ready can assert in the cycle after N, so the first beat is accepted at edge N+1.
  - Gap between packets: the last beat accepted at edge N returns the FSM to IDLE. The next packet's first beat is accepted no earlier than edge N+2, i.e. one idle input cycle.
- Packet integrity:
  - Beats of different packets never interleave on y.
  - A requester dropping valid mid-packet keeps the grant; the arbiter waits indefinitely.
- Single-beat packets (last=1 on the first beat) are legal: grant, one transfer, back to IDLE.
- busy = (state != IDLE). sel is registered and changes only on an IDLE->GNT transition.
- Mid-operation reset:
  - Any in-flight packet is abandoned; y_valid drops to 0 immediately (asynchronous).
  - Priority returns to a-first after reset release.
- Inputs are assumed stable while valid & ~ready. The arbiter does not check this.

Test Plan:
- Reset, then a_valid=b_valid=1, both 1-beat packets (a_data=0x11, b_data=0x22), y_ready=1 -> y sequence 0x11 then 0x22; sel 0 then 1; one idle input cycle between packets.
- a sends 3-beat packet 0xA0,0xA1,0xA2 (last on 0xA2); b_valid raised during beat 2 with 0xB0 -> y = A0,A1,A2,B0 with no interleave; b_ready=0 until after A2 accepted and IDLE passed.
- Both requesters continuously send 1-beat packets for 6 packets -> grants alternate a,b,a,b,a,b; last_served toggles each packet.
- y_ready held 0 for 4 cycles after first beat 0x55 loaded -> y_valid=1, y_data=0x55 stable, a_ready=0. y_ready=1 -> next beat accepted the same edge old one drains, y_valid stays 1.
- a_valid dropped for 3 cycles mid-packet while b_valid=1 -> state stays GNT_A, b_ready=0, busy=1; a resumes and finishes -> b granted next.
- rst asserted while GNT_B with y_valid=1 -> y_valid, busy, sel, readies go 0 without a clock edge. After release with both valid -> a granted first.
